// File: rtl/lock_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : lock_controller_if
//  Purpose  : Bundles the keypad/command inputs and the status outputs of the
//             combination lock into one interface.
//  Signals  : btn      [3:0]  one-hot digit pulses (bit i = digit i)
//             lock_cmd        single-cycle relock request
//             prog            single-cycle program-new-code request
//             status   [1:0]  00 idle, 01 failed, 10 unlocked
//             count    [3:0]  digits entered so far (0..3)
//             lockout         high during the extended lockout hold
//  Modports : master (keypad side) drives the inputs, slave (lock) the outputs
//  Revision : 1.0  initial release
// ============================================================================
interface lock_controller_if;
    logic [3:0] btn;
    logic       lock_cmd;
    logic       prog;
    logic [1:0] status;
    logic [3:0] count;
    logic       lockout;

    modport master (
        output btn,
        output lock_cmd,
        output prog,
        input  status,
        input  count,
        input  lockout
    );

    modport slave (
        input  btn,
        input  lock_cmd,
        input  prog,
        output status,
        output count,
        output lockout
    );
endinterface
`default_nettype wire

// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lock_controller
//  Purpose  : Three-digit combination lock with failure counting, timed
//             failure hold / lockout, inactivity timeout and code programming.
//  Ports    : clk    - single rising-edge clock
//             reset  - synchronous, active-low reset
//             bus    - lock_controller_if.slave (btn, lock_cmd, prog in;
//                      status, count, lockout out, all registered)
//  Revision : 1.0  initial release
// ============================================================================
module lock_controller #(
    parameter logic [5:0]  DEFAULT_CODE = 6'b00_01_10,
    parameter logic [25:0] TIMEOUT      = 26'd10_000_000,
    parameter logic [25:0] FAIL_HOLD    = 26'd5_000_000,
    parameter logic [1:0]  MAX_FAILS    = 2'd3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    lock_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_FAILED   = 3'd2,
        S_UNLOCKED = 3'd3,
        S_PROGRAM  = 3'd4
    } state_t;

    localparam logic [1:0] C_ST_IDLE     = 2'b00;
    localparam logic [1:0] C_ST_FAILED   = 2'b01;
    localparam logic [1:0] C_ST_UNLOCKED = 2'b10;

    // The shared timer is wide enough for the 4x lockout hold.
    localparam logic [27:0] C_TIMEOUT_LAST   = {2'b00, TIMEOUT} - 28'd1;
    localparam logic [27:0] C_HOLD_LAST      = {2'b00, FAIL_HOLD} - 28'd1;
    localparam logic [27:0] C_LOCK_HOLD_LAST = {FAIL_HOLD, 2'b00} - 28'd1;

    state_t      state_q,    state_d;
    logic [1:0]  status_q,   status_d;
    logic [3:0]  count_q,    count_d;
    logic        lockout_q,  lockout_d;
    logic [1:0]  fails_q,    fails_d;
    logic [27:0] timer_q,    timer_d;
    logic        mismatch_q, mismatch_d;
    logic [5:0]  shadow_q,   shadow_d;
    logic [5:0]  code_q,     code_d;

    logic        w_press;
    logic [1:0]  w_digit;
    logic [1:0]  w_expected;
    logic [1:0]  w_fails_inc;
    logic        w_timeout;
    logic        w_hold_done;

    // Exactly one bit set counts as a press; zero or multiple bits are ignored.
    assign w_press = (bus.btn != 4'b0000) && ((bus.btn & (bus.btn - 4'd1)) == 4'b0000);

    always_comb begin
        w_digit = 2'd0;
        case (bus.btn)
            4'b0010: w_digit = 2'd1;
            4'b0100: w_digit = 2'd2;
            4'b1000: w_digit = 2'd3;
            default: w_digit = 2'd0;
        endcase
    end

    // Stored digit the next press is compared against, selected by the
    // number of digits already entered.
    always_comb begin
        w_expected = code_q[1:0];
        case (count_q[1:0])
            2'd0:    w_expected = code_q[5:4];
            2'd1:    w_expected = code_q[3:2];
            default: w_expected = code_q[1:0];
        endcase
    end

    assign w_fails_inc = (fails_q >= MAX_FAILS) ? MAX_FAILS : (fails_q + 2'd1);
    assign w_timeout   = (timer_q == C_TIMEOUT_LAST);
    // lockout_q is set on entry to FAILED, so it selects the hold length.
    assign w_hold_done = lockout_q ? (timer_q == C_LOCK_HOLD_LAST)
                                   : (timer_q == C_HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        count_d    = count_q;
        lockout_d  = lockout_q;
        fails_d    = fails_q;
        timer_d    = timer_q;
        mismatch_d = mismatch_q;
        shadow_d   = shadow_q;
        code_d     = code_q;

        case (state_q)
            S_IDLE: begin
                status_d  = C_ST_IDLE;
                count_d   = 4'd0;
                lockout_d = 1'b0;
                timer_d   = 28'd0;
                if (w_press) begin
                    state_d    = S_ENTRY;
                    count_d    = 4'd1;
                    mismatch_d = (w_digit != w_expected);
                end
            end

            S_ENTRY: begin
                status_d = C_ST_IDLE;
                if (count_q == 4'd3) begin
                    // Third digit was registered last edge; resolve now.
                    count_d = 4'd0;
                    timer_d = 28'd0;
                    if (mismatch_q) begin
                        state_d   = S_FAILED;
                        status_d  = C_ST_FAILED;
                        fails_d   = w_fails_inc;
                        lockout_d = (w_fails_inc == MAX_FAILS);
                    end else begin
                        state_d  = S_UNLOCKED;
                        status_d = C_ST_UNLOCKED;
                        fails_d  = 2'd0;
                    end
                end else if (w_press) begin
                    count_d    = count_q + 4'd1;
                    mismatch_d = mismatch_q | (w_digit != w_expected);
                    timer_d    = 28'd0;
                end else if (w_timeout) begin
                    state_d  = S_IDLE;
                    count_d  = 4'd0;
                    timer_d  = 28'd0;
                end else begin
                    timer_d = timer_q + 28'd1;
                end
            end

            S_FAILED: begin
                status_d = C_ST_FAILED;
                count_d  = 4'd0;
                if (w_hold_done) begin
                    state_d    = S_IDLE;
                    status_d   = C_ST_IDLE;
                    lockout_d  = 1'b0;
                    timer_d    = 28'd0;
                    mismatch_d = 1'b0;
                end else begin
                    timer_d = timer_q + 28'd1;
                end
            end

            S_UNLOCKED: begin
                status_d = C_ST_UNLOCKED;
                count_d  = 4'd0;
                timer_d  = 28'd0;
                if (bus.lock_cmd) begin
                    state_d  = S_IDLE;
                    status_d = C_ST_IDLE;
                end else if (bus.prog) begin
                    state_d  = S_PROGRAM;
                    shadow_d = 6'd0;
                end
            end

            S_PROGRAM: begin
                status_d = C_ST_UNLOCKED;
                if (bus.lock_cmd) begin
                    state_d  = S_IDLE;
                    status_d = C_ST_IDLE;
                    count_d  = 4'd0;
                    timer_d  = 28'd0;
                end else if (count_q == 4'd3) begin
                    // Whole new code committed in one edge.
                    code_d  = shadow_q;
                    state_d = S_UNLOCKED;
                    count_d = 4'd0;
                    timer_d = 28'd0;
                end else if (w_press) begin
                    count_d  = count_q + 4'd1;
                    shadow_d = {shadow_q[3:0], w_digit};
                    timer_d  = 28'd0;
                end else if (w_timeout) begin
                    state_d = S_UNLOCKED;
                    count_d = 4'd0;
                    timer_d = 28'd0;
                end else begin
                    timer_d = timer_q + 28'd1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                status_d  = C_ST_IDLE;
                count_d   = 4'd0;
                lockout_d = 1'b0;
                timer_d   = 28'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            status_q   <= C_ST_IDLE;
            count_q    <= 4'd0;
            lockout_q  <= 1'b0;
            fails_q    <= 2'd0;
            timer_q    <= 28'd0;
            mismatch_q <= 1'b0;
            shadow_q   <= 6'd0;
            code_q     <= DEFAULT_CODE;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            count_q    <= count_d;
            lockout_q  <= lockout_d;
            fails_q    <= fails_d;
            timer_q    <= timer_d;
            mismatch_q <= mismatch_d;
            shadow_q   <= shadow_d;
            code_q     <= code_d;
        end
    end

    assign bus.status  = status_q;
    assign bus.count   = count_q;
    assign bus.lockout = lockout_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lock_controller
//  Purpose  : Self-checking bench for lock_controller (TIMEOUT=20,
//             FAIL_HOLD=10). Expected {status,count,lockout} tuples are queued
//             as each cycle's stimulus is applied and checked after the edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lock_controller;

    logic clk;
    logic reset;

    lock_controller_if bus_if ();

    lock_controller #(
        .DEFAULT_CODE (6'b00_01_10),
        .TIMEOUT      (26'd20),
        .FAIL_HOLD    (26'd10),
        .MAX_FAILS    (2'd3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    function automatic logic [6:0] pack(input logic [1:0] st, input logic [3:0] cnt, input logic lo);
        return {st, cnt, lo};
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got status=%b count=%0d lockout=%b, expected status=%b count=%0d lockout=%b",
                     tag, got[6:5], got[4:1], got[0], exp[6:5], exp[4:1], exp[0]);
        end
    endtask

    // One clock with the given inputs held across the rising edge.
    task automatic step(input logic [3:0] b, input logic lk, input logic pg);
        bus_if.btn      = b;
        bus_if.lock_cmd = lk;
        bus_if.prog     = pg;
        @(posedge clk);
        #1;
        bus_if.btn      = 4'b0000;
        bus_if.lock_cmd = 1'b0;
        bus_if.prog     = 1'b0;
    endtask

    task automatic step_exp(input string tag, input logic [3:0] b, input logic lk,
                            input logic pg, input logic [6:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        step(b, lk, pg);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, {bus_if.status, bus_if.count, bus_if.lockout}, e.exp);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 1'b0);
    endtask

    // Three presses with gaps; count 1..3 with the given status.
    task automatic enter_code(input string tag, input logic [3:0] b1, input logic [3:0] b2,
                              input logic [3:0] b3, input logic [1:0] st);
        step_exp({tag, "_d1"}, b1, 1'b0, 1'b0, pack(st, 4'd1, 1'b0));
        quiet(2);
        step_exp({tag, "_d2"}, b2, 1'b0, 1'b0, pack(st, 4'd2, 1'b0));
        quiet(2);
        step_exp({tag, "_d3"}, b3, 1'b0, 1'b0, pack(st, 4'd3, 1'b0));
    endtask

    // Evaluation edge plus the whole hold; presses during it must not count.
    task automatic fail_hold(input string tag, input int cycles, input logic lo);
        for (int i = 0; i < cycles; i++)
            step_exp({tag, "_hold"}, (i % 2 == 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b0,
                     pack(2'b01, 4'd0, lo));
        step_exp({tag, "_end"}, 4'b0000, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        bus_if.btn      = 4'b0000;
        bus_if.lock_cmd = 1'b0;
        bus_if.prog     = 1'b0;
        reset           = 1'b0;
        @(posedge clk);
        #1;
        step_exp("reset", 4'b0000, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));
        reset = 1'b1;

        // Inputs that must do nothing in IDLE.
        step_exp("idle_multi", 4'b0011, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));
        step_exp("idle_prog",  4'b0000, 1'b0, 1'b1, pack(2'b00, 4'd0, 1'b0));
        step_exp("idle_lock",  4'b0000, 1'b1, 1'b0, pack(2'b00, 4'd0, 1'b0));

        // Correct default code 0,1,2.
        enter_code("ok", 4'b0001, 4'b0010, 4'b0100, 2'b00);
        step_exp("ok_unlock", 4'b0001, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));
        step_exp("unl_press", 4'b0001, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));
        step_exp("relock", 4'b0000, 1'b1, 1'b0, pack(2'b00, 4'd0, 1'b0));

        // Three consecutive wrong codes; the third triggers lockout.
        enter_code("w1", 4'b0001, 4'b0001, 4'b0001, 2'b00);
        fail_hold("w1", 10, 1'b0);
        enter_code("w2", 4'b0001, 4'b0010, 4'b0001, 2'b00);
        fail_hold("w2", 10, 1'b0);
        enter_code("w3", 4'b1000, 4'b0010, 4'b0100, 2'b00);
        fail_hold("w3", 40, 1'b1);
        enter_code("after_lo", 4'b0001, 4'b0010, 4'b0100, 2'b00);
        step_exp("after_lo_unlock", 4'b0000, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));
        step_exp("relock2", 4'b0000, 1'b1, 1'b0, pack(2'b00, 4'd0, 1'b0));

        // Inactivity timeout, then a press exactly in the expiry cycle.
        step_exp("to_p1", 4'b0001, 1'b0, 1'b0, pack(2'b00, 4'd1, 1'b0));
        step_exp("to_multi", 4'b0011, 1'b0, 1'b0, pack(2'b00, 4'd1, 1'b0));
        quiet(17);
        step_exp("to_q19", 4'b0000, 1'b0, 1'b0, pack(2'b00, 4'd1, 1'b0));
        step_exp("to_q20", 4'b0000, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));
        step_exp("exp_p1", 4'b0001, 1'b0, 1'b0, pack(2'b00, 4'd1, 1'b0));
        quiet(19);
        step_exp("exp_p2", 4'b0010, 1'b0, 1'b0, pack(2'b00, 4'd2, 1'b0));
        quiet(19);
        step_exp("exp_clear", 4'b0000, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));

        // Program new code 3,3,0.
        enter_code("pg_unl", 4'b0001, 4'b0010, 4'b0100, 2'b00);
        step_exp("pg_unl_ok", 4'b0000, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));
        step_exp("pg_enter", 4'b0000, 1'b0, 1'b1, pack(2'b10, 4'd0, 1'b0));
        step_exp("pg_d1", 4'b1000, 1'b0, 1'b0, pack(2'b10, 4'd1, 1'b0));
        step_exp("pg_multi", 4'b0011, 1'b0, 1'b0, pack(2'b10, 4'd1, 1'b0));
        step_exp("pg_d2", 4'b1000, 1'b0, 1'b0, pack(2'b10, 4'd2, 1'b0));
        step_exp("pg_d3", 4'b0001, 1'b0, 1'b0, pack(2'b10, 4'd3, 1'b0));
        step_exp("pg_commit", 4'b0000, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));
        step_exp("pg_lock", 4'b0000, 1'b1, 1'b0, pack(2'b00, 4'd0, 1'b0));
        enter_code("old", 4'b0001, 4'b0010, 4'b0100, 2'b00);
        fail_hold("old", 10, 1'b0);
        enter_code("new", 4'b1000, 4'b1000, 4'b0001, 2'b00);
        step_exp("new_unlock", 4'b0000, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));

        // prog and lock_cmd together: lock wins, then a press proves IDLE.
        step_exp("both", 4'b0000, 1'b1, 1'b1, pack(2'b00, 4'd0, 1'b0));
        step_exp("both_idle", 4'b0001, 1'b0, 1'b0, pack(2'b00, 4'd1, 1'b0));
        quiet(19);
        step_exp("both_to", 4'b0000, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));

        // Reset in the middle of programming.
        enter_code("rp_unl", 4'b1000, 4'b1000, 4'b0001, 2'b00);
        step_exp("rp_unl_ok", 4'b0000, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));
        step_exp("rp_prog", 4'b0000, 1'b0, 1'b1, pack(2'b10, 4'd0, 1'b0));
        step_exp("rp_d1", 4'b0100, 1'b0, 1'b0, pack(2'b10, 4'd1, 1'b0));
        step_exp("rp_d2", 4'b0100, 1'b0, 1'b0, pack(2'b10, 4'd2, 1'b0));
        reset = 1'b0;
        step_exp("rp_reset", 4'b0100, 1'b0, 1'b0, pack(2'b00, 4'd0, 1'b0));
        reset = 1'b1;
        enter_code("rp_def", 4'b0001, 4'b0010, 4'b0100, 2'b00);
        step_exp("rp_def_unlock", 4'b0000, 1'b0, 1'b0, pack(2'b10, 4'd0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
